// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - encodes MIPS instruction fields into words and streams them into an instruction memory.
// Optional macro IMEM_LOADER_CHECK_EN: invalid in_kind is flagged and dropped instead of written as zero.
module imem_loader #(
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] BASE_A = BASE[AW-1:0];
`ifdef IMEM_LOADER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic          pend_last;
  logic          last_seen;
  logic [31:0]   word;
  logic          kind_ok;
  logic          drop;
  logic          accept;
  logic          wr_done;
  logic [AW+1:0] fill;

  // imem_we doubles as the "output register full" flag.
  assign fill     = {1'b0, count} + {{(AW + 1){1'b0}}, imem_we};
  assign in_ready = (state == LOAD) && (!imem_we || imem_ready) && !last_seen
                    && (fill < (AW + 2)'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign wr_done  = imem_we && imem_ready;
  assign drop     = CHECK_EN && !kind_ok;

  always_comb begin
    word    = 32'h0;
    kind_ok = 1'b1;
    case (in_kind)
      4'd0:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, in_funct};
      4'd1:    word = {6'b100011, in_rs, in_rt, in_imm};
      4'd2:    word = {6'b101011, in_rs, in_rt, in_imm};
      4'd3:    word = {6'b000100, in_rs, in_rt, in_imm};
      4'd4:    word = {6'b001000, in_rs, in_rt, in_imm};
      4'd5:    word = {6'b000010, in_target};
      4'd6:    word = {6'b001010, in_rs, in_rt, in_imm};
      4'd7:    word = {6'b001111, 5'b0, in_rt, in_imm};
      4'd8:    word = {6'b000110, in_rs, 5'b0, in_imm};
      default: kind_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_A;
      imem_wdata <= 32'h0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pend_last  <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            imem_we   <= 1'b0;
            imem_addr <= BASE_A;
            count     <= '0;
            err       <= 1'b0;
            pend_last <= 1'b0;
            last_seen <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        LOAD: begin
          if (wr_done) begin
            imem_we   <= 1'b0;
            imem_addr <= imem_addr + 1'b1;
            count     <= count + 1'b1;
          end
          // A new accept may refill the register in the same cycle it drains.
          if (accept) begin
            last_seen <= in_last;
            if (drop) begin
              err <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_wdata <= word;
              pend_last  <= in_last;
            end
          end
          if ((wr_done && pend_last) || (accept && drop && in_last)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (wr_done && count == (AW + 1)'(DEPTH - 1)) begin
            err   <= 1'b1;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized bench for imem_loader against a queue-based reference of expected writes.
// Honours IMEM_LOADER_CHECK_EN the same way the design does.
module tb_imem_loader;

  localparam int AW    = 3;
  localparam int BASE  = 6;
  localparam int DEPTH = 1 << AW;
`ifdef IMEM_LOADER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          imem_we;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  imem_loader #(.AW(AW), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } instr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  instr_t prog[$];
  wr_t    exp_q[$];
  bit     exp_err;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input int kind, input int rs, input int rt, input int rd,
                                input int funct, input int imm, input int target, input bit last);
    instr_t i;
    i.kind = 4'(kind); i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    i.funct = 6'(funct); i.imm = 16'(imm); i.target = 26'(target); i.last = last;
    return i;
  endfunction

  function automatic instr_t rand_instr(input bit last);
    int k;
    k = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
    return mk(k, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, last);
  endfunction

  // MIPS opcodes by in_kind, then the word layout by instruction format.
  function automatic logic [31:0] ref_word(input instr_t i);
    logic [5:0] op;
    case (i.kind)
      4'd0: op = 6'd0;   4'd1: op = 6'd35;  4'd2: op = 6'd43;
      4'd3: op = 6'd4;   4'd4: op = 6'd8;   4'd5: op = 6'd2;
      4'd6: op = 6'd10;  4'd7: op = 6'd15;  4'd8: op = 6'd6;
      default: return 32'h0;
    endcase
    case (i.kind)
      4'd0:    return {op, i.rs, i.rt, i.rd, 5'd0, i.funct};
      4'd5:    return {op, i.target};
      4'd7:    return {op, 5'd0, i.rt, i.imm};
      4'd8:    return {op, i.rs, 5'd0, i.imm};
      default: return {op, i.rs, i.rt, i.imm};
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] d);
    wr_t w;
    w.addr = AW'((BASE + exp_q.size()) % DEPTH);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic build_expected();
    exp_q.delete();
    exp_err = 1'b0;
    foreach (prog[i]) begin
      if (CHECK_EN && prog[i].kind > 4'd8) begin
        exp_err = 1'b1;
        if (prog[i].last) break;
        continue;
      end
      push_exp(ref_word(prog[i]));
      if (prog[i].last) break;
      if (exp_q.size() == DEPTH) begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive(input instr_t i);
    in_kind = i.kind; in_rs = i.rs; in_rt = i.rt; in_rd = i.rd;
    in_funct = i.funct; in_imm = i.imm; in_target = i.target; in_last = i.last;
  endtask

  task automatic run_session(input string tag, input int ready_pct, input int hold, input bit b2b);
    int idx = 0;
    int wr = 0;
    int cyc = 0;
    int last_wr_cyc = -1;
    bit acc;
    bit acc_valid = 1'b0;
    bit held = 1'b0;
    bit fin = 1'b0;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_data;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!fin && cyc < 300) begin
      imem_ready = (cyc >= hold) && ($urandom_range(1, 100) <= ready_pct);
      in_valid = (idx < prog.size());
      if (in_valid) drive(prog[idx]);
      start = busy && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (acc_valid) check({tag, " latency"}, 32'(imem_we), 32'd1);
      if (held) begin
        check({tag, " hold we"}, 32'(imem_we), 32'd1);
        check({tag, " hold addr"}, 32'(imem_addr), 32'(h_addr));
        check({tag, " hold data"}, imem_wdata, h_data);
      end
      if (imem_we && !imem_ready) check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
      acc = in_valid && in_ready;
      if (acc) acc_valid = !(CHECK_EN && prog[idx].kind > 4'd8);
      else acc_valid = 1'b0;
      held = imem_we && !imem_ready;
      h_addr = imem_addr;
      h_data = imem_wdata;
      if (imem_we && imem_ready) begin
        if (wr < exp_q.size()) begin
          check({tag, " addr"}, 32'(imem_addr), 32'(exp_q[wr].addr));
          check({tag, " data"}, imem_wdata, exp_q[wr].data);
          check({tag, " running count"}, 32'(count), 32'(wr));
          if (b2b && last_wr_cyc >= 0) check({tag, " b2b gap"}, 32'(cyc - last_wr_cyc), 32'd1);
        end else begin
          check({tag, " extra write"}, 32'(wr), 32'(exp_q.size()));
        end
        last_wr_cyc = cyc;
        wr++;
      end
      fin = done;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    imem_ready = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " writes"}, 32'(wr), 32'(exp_q.size()));
    check({tag, " count"}, 32'(count), 32'(exp_q.size()));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " imem_we"}, 32'(imem_we), 32'd0);
    check({tag, " imem_addr"}, 32'(imem_addr), 32'(BASE % DEPTH));
    check({tag, " imem_wdata"}, imem_wdata, 32'h0);
    check({tag, " count"}, 32'(count), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic reset_mid_write();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drive(mk(4, 1, 2, 0, 0, 5, 0, 1'b1));
    in_valid = 1'b1;
    imem_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("rst pre imem_we", 32'(imem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async rst");
    @(posedge clk); #1 rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post rst imem_we", 32'(imem_we), 32'd0);
      check("post rst busy", 32'(busy), 32'd0);
    end
    imem_ready = 1'b0;
  endtask

  initial begin
    instr_t t;
    int nvalid;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1'b0));
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    rst_n = 1'b1;

    prog = '{mk(4, 1, 2, 0, 0, 16'h0005, 0, 1'b1)};
    exp_q.delete(); exp_err = 1'b0;
    push_exp(32'h2022_0005);
    run_session("addi", 100, 0, 1'b1);

    prog = '{mk(0, 1, 2, 3, 6'h20, 0, 0, 1'b0), mk(7, 0, 4, 0, 0, 16'h1234, 0, 1'b0),
             mk(5, 0, 0, 0, 0, 0, 26'h0000100, 1'b1)};
    exp_q.delete(); exp_err = 1'b0;
    push_exp(32'h0022_1820); push_exp(32'h3C04_1234); push_exp(32'h0800_0100);
    run_session("b2b", 100, 0, 1'b1);

    prog = '{mk(8, 5, 0, 0, 0, 16'hFFFE, 0, 1'b1)};
    exp_q.delete(); exp_err = 1'b0;
    push_exp(32'h18A0_FFFE);
    run_session("blez_hold", 100, 4, 1'b0);

    prog.delete();
    for (int i = 0; i <= DEPTH; i++) prog.push_back(mk(4, $urandom, $urandom, 0, 0, $urandom, 0, 1'b0));
    build_expected();
    run_session("overflow", 100, 0, 1'b1);

    prog = '{mk(4, 1, 2, 0, 0, 16'h0005, 0, 1'b0), mk(12, 3, 3, 3, 3, 3, 3, 1'b0),
             mk(7, 0, 4, 0, 0, 16'h1234, 0, 1'b1)};
    exp_q.delete();
    push_exp(32'h2022_0005);
`ifdef IMEM_LOADER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
    push_exp(32'h0000_0000);
`endif
    push_exp(32'h3C04_1234);
    run_session("invalid_kind", 100, 0, 1'b0);

    for (int s = 0; s < 25; s++) begin
      prog.delete();
      if ($urandom_range(0, 4) != 0) begin
        for (int i = $urandom_range(1, 7); i > 1; i--) prog.push_back(rand_instr(1'b0));
        prog.push_back(rand_instr(1'b1));
      end else begin
        nvalid = 0;
        while (nvalid <= DEPTH) begin
          t = rand_instr(1'b0);
          if (!(CHECK_EN && t.kind > 4'd8)) nvalid++;
          prog.push_back(t);
        end
      end
      build_expected();
      run_session($sformatf("rand%0d", s), $urandom_range(30, 100), $urandom_range(0, 3), 1'b0);
    end

    reset_mid_write();

    prog = '{rand_instr(1'b0), rand_instr(1'b1)};
    build_expected();
    run_session("after_rst", 70, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter AW, default 8: imem word-address width; DEPTH = 2**AW words.
REQ-002 Parameter BASE, default 0: first word address written after start.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  begin a load session; sampled only in IDLE or DONE.
REQ-006 in_valid / in_ready  in / out  1 / 1  instruction-field handshake; transfer when both high.
REQ-007 in_kind  in  4  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6=SLTI, 7=LUI, 8=BLEZ, 9-15 invalid.
REQ-008 in_rs, in_rt, in_rd  in  5 each; in_funct  in  6; in_imm  in  16; in_target  in  26; in_last  in  1 (final instruction of session).
REQ-009 imem_we / imem_ready  out / in  1 / 1  write handshake; write completes when both high.
REQ-010 imem_addr  out  AW;  imem_wdata  out  32  encoded MIPS word.
REQ-011 busy, done, err  out  1 each;  count  out  AW+1  words written this session.

Function
REQ-012 States IDLE, LOAD, DONE; start in IDLE or DONE -> LOAD next cycle, address <= BASE, count <= 0, err <= 0.
REQ-013 in_ready = 1 only in LOAD when output register empty or imem_ready high that cycle, and no in_last already accepted, and count + occupancy < DEPTH.
REQ-014 Encoding, op field [31:26]: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, SLTI 001010, LUI 001111, BLEZ 000110.
REQ-015 R word = {op, rs, rt, rd, 5'b0, funct}; LW/SW/BEQ/ADDI/SLTI = {op, rs, rt, imm}; LUI = {op, 5'b0, rt, imm}; BLEZ = {op, rs, 5'b0, imm}; J = {op, target}.
REQ-016 Accepted field set is encoded into a one-entry output register; imem_we rises the cycle after acceptance (latency 1).
REQ-017 imem_we, imem_addr, imem_wdata held stable until imem_ready; accept and write-complete in same cycle allowed (back-to-back, one word per cycle).
REQ-018 On each write completion: imem_addr increments (wraps modulo DEPTH from BASE), count increments.
REQ-019 When the in_last word completes its write, LOAD -> DONE.
REQ-020 When count reaches DEPTH with no in_last seen, err <= 1 and LOAD -> DONE.
REQ-021 busy = 1 in LOAD; done = 1 in DONE; err sticky until next start.
REQ-022 start while in LOAD ignored.

Reset
REQ-023 rst_n low -> state IDLE, imem_we 0, imem_addr BASE, imem_wdata 0, count 0, busy 0, done 0, err 0, in_ready 0, output register empty.
REQ-024 Reset mid-write drops the pending word; no further imem_we until a new start.

Configuration
REQ-025 Macro IMEM_LOADER_CHECK_EN defined: invalid in_kind (9-15) is accepted, sets err, is not written, count unchanged; if it carries in_last, session still -> DONE.
REQ-026 Macro IMEM_LOADER_CHECK_EN undefined: invalid in_kind is written as 32'h0000_0000 and counted; err set only by REQ-020.

Verification
REQ-027 start, then kind=4 ADDI rs=1 rt=2 imm=16'h0005 last=1, imem_ready=1 -> imem_we next cycle, addr 0, wdata 32'h2022_0005; then done=1, count=1.
REQ-028 Back-to-back R(rs=1,rt=2,rd=3,funct=6'h20), LUI(rt=4,imm=16'h1234), J(target=26'h0000100, last) with imem_ready=1 -> words 32'h0022_1820, 32'h3C04_1234, 32'h0800_0100 at addr 0,1,2 on consecutive cycles.
REQ-029 imem_ready held 0 for 3 cycles during BLEZ(rs=5,imm=16'hFFFE) -> wdata 32'h18A0_FFFE and addr stable, in_ready 0, write completes when imem_ready rises.
REQ-030 AW=2, 5 instructions without last -> 4 writes, err=1, DONE, in_ready 0 thereafter.
REQ-031 With IMEM_LOADER_CHECK_EN, kind=12 between two valid words -> err=1, only 2 words written at addr 0,1; without the macro -> 3 words, middle 32'h0.
REQ-032 rst_n low while imem_we=1 -> all outputs at REQ-023 values asynchronously; after release no imem_we until start.
